cp0_core_param: RTL and testbench

Parametrised CP0 system-control block for the MIPS pipeline, successor to the fixed single-timer CP0. Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config; services MFC0/MTC0; commits precise exceptions and ERET from the MEM-stage exception unit. Adds a programmable Count prescaler, sticky timer interrupt (Cause.TI), synchronised hardware interrupt lines and a registered interrupt-pending output to the exception unit.

---
 rtl/cp0_core_param_pkg.sv | 81 ++++++++
 rtl/cp0_timer.sv | 65 ++++++
 rtl/cp0_core_param.sv | 132 +++++++++++++
 tb/tb_cp0_core_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_core_param_pkg.sv
// Shared CP0 types, register addresses, exception codes and reset image
// for the parametrised CP0 block and its timer.
package cp0_core_param_pkg;

    localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;
    localparam logic [4:0] CP0_ADDR_PRID     = 5'd15;
    localparam logic [4:0] CP0_ADDR_CONFIG   = 5'd16;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    typedef struct packed {
        logic [8:0] rsvd_hi;
        logic       bev;
        logic [5:0] rsvd_mid;
        logic [7:0] im;
        logic [4:0] rsvd_lo;
        logic       erl;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd_hi;
        logic [7:0]  ip;
        logic        rsvd_mid;
        logic [4:0]  exccode;
        logic [1:0]  rsvd_lo;
    } cp0_cause_t;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic [31:0] epc;
        cp0_status_t status;
        cp0_cause_t  cause;
    } cp0_regs_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [2:0] sel;
    } cp0_rreq_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [2:0]  sel;
        logic [31:0] wdata;
    } cp0_wreq_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        delayslot;
        logic [31:0] badvaddr;
        logic        is_eret;
    } exception_sign_t;

    typedef struct packed {
        logic [4:0] exccode;
    } exception_data_t;

    localparam cp0_regs_t CP0_INIT = '{
        badvaddr: 32'h0,
        epc:      32'h0,
        status:   cp0_status_t'(32'h0040_0000),
        cause:    cp0_cause_t'(32'h0)
    };

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and sticky TI flag.
import cp0_core_param_pkg::*;

module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_reg, presc_next;
    logic [31:0]   count_reg, count_next;
    logic [31:0]   compare_reg, compare_next;
    logic          ti_reg, ti_next;

    always_comb begin
        presc_next   = presc_reg;
        count_next   = count_reg;
        compare_next = compare_reg;
        ti_next      = ti_reg;
        if (count_we) begin
            count_next = wdata;
            presc_next = '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            count_next = count_reg + 32'd1;
        end else begin
            presc_next = presc_reg + 1'b1;
        end
        // A Compare write both acknowledges and re-arms, beating a same-cycle match.
        if (compare_we) begin
            compare_next = wdata;
            ti_next      = 1'b0;
        end else if (count_reg == compare_reg) begin
            ti_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg   <= '0;
            count_reg   <= '0;
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else begin
            presc_reg   <= presc_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            ti_reg      <= ti_next;
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;

endmodule

// File: rtl/cp0_core_param.sv
// CP0 system-control block: MFC0/MTC0, precise exception/ERET commit,
// synchronised hardware interrupts and registered interrupt request.
import cp0_core_param_pkg::*;

module cp0_core_param #(
    parameter int          N_HW_INT   = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000,
    parameter int          TIMER_IP   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  cp0_rreq_t           cp0_rreq,
    output logic [31:0]         cp0_rdata,
    input  cp0_wreq_t           cp0_wreq,
    input  logic [N_HW_INT-1:0] hw_int,
    input  exception_sign_t     exception_sign,
    input  exception_data_t     exception_data,
    output logic [31:0]         cp0_status,
    output logic [31:0]         cp0_cause,
    output logic [31:0]         cp0_epc,
    output logic                timer_interrupt,
    output logic                int_pending
);
    cp0_regs_t           regs_reg, regs_next;
    logic [N_HW_INT-1:0] sync1_reg, sync2_reg;
    logic                int_pending_reg, int_pending_next;
    logic [31:0]         count, compare;
    logic                ti;
    logic [7:0]          ip;
    cp0_cause_t          cause_view;
    logic                count_we, compare_we;
    logic                unused_bits;

    assign count_we   = cp0_wreq.we && (cp0_wreq.addr == CP0_ADDR_COUNT);
    assign compare_we = cp0_wreq.we && (cp0_wreq.addr == CP0_ADDR_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (cp0_wreq.wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // IP[1:0] are software bits; the rest come live from the sync chain and timer.
    always_comb begin
        ip                = 8'h00;
        ip[1:0]           = regs_reg.cause.ip[1:0];
        ip[2 +: N_HW_INT] = sync2_reg;
        ip[TIMER_IP]      = ip[TIMER_IP] | ti;
        cause_view        = regs_reg.cause;
        cause_view.ti     = ti;
        cause_view.ip     = ip;
    end

    always_comb begin
        regs_next = regs_reg;
        if (cp0_wreq.we) begin
            case (cp0_wreq.addr)
                CP0_ADDR_STATUS: begin
                    regs_next.status.im  = cp0_wreq.wdata[15:8];
                    regs_next.status.exl = cp0_wreq.wdata[1];
                    regs_next.status.ie  = cp0_wreq.wdata[0];
                end
                CP0_ADDR_CAUSE: regs_next.cause.ip[1:0] = cp0_wreq.wdata[9:8];
                CP0_ADDR_EPC:   regs_next.epc = cp0_wreq.wdata;
                default: ;
            endcase
        end
        if (exception_sign.is_eret) begin
            if (regs_reg.status.erl) regs_next.status.erl = 1'b0;
            else                     regs_next.status.exl = 1'b0;
        end
        if (exception_sign.valid) begin
            regs_next.status.exl    = 1'b1;
            regs_next.cause.exccode = exception_data.exccode;
            regs_next.epc           = regs_reg.epc;
            // Nested exceptions keep the original return point.
            if (!regs_reg.status.exl) begin
                regs_next.epc      = exception_sign.delayslot ? exception_sign.pc - 32'd4
                                                              : exception_sign.pc;
                regs_next.cause.bd = exception_sign.delayslot;
            end
            if (exception_data.exccode == CODE_ADEL || exception_data.exccode == CODE_ADES)
                regs_next.badvaddr = exception_sign.badvaddr;
        end
        int_pending_next = regs_reg.status.ie & ~regs_reg.status.exl & ~regs_reg.status.erl
                         & (|(ip & regs_reg.status.im));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_reg        <= CP0_INIT;
            sync1_reg       <= '0;
            sync2_reg       <= '0;
            int_pending_reg <= 1'b0;
        end else begin
            regs_reg        <= regs_next;
            sync1_reg       <= hw_int;
            sync2_reg       <= sync1_reg;
            int_pending_reg <= int_pending_next;
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_rreq.addr)
            CP0_ADDR_BADVADDR: cp0_rdata = regs_reg.badvaddr;
            CP0_ADDR_COUNT:    cp0_rdata = count;
            CP0_ADDR_COMPARE:  cp0_rdata = compare;
            CP0_ADDR_STATUS:   cp0_rdata = regs_reg.status;
            CP0_ADDR_CAUSE:    cp0_rdata = cause_view;
            CP0_ADDR_EPC:      cp0_rdata = regs_reg.epc;
            CP0_ADDR_PRID:     cp0_rdata = (cp0_rreq.sel == 3'd0) ? PRID_VAL : 32'h0;
            CP0_ADDR_CONFIG:   cp0_rdata = CONFIG_VAL;
            default:           cp0_rdata = 32'h0;
        endcase
    end

    assign cp0_status      = regs_reg.status;
    assign cp0_cause       = cause_view;
    assign cp0_epc         = regs_reg.epc;
    assign timer_interrupt = ti;
    assign int_pending     = int_pending_reg;
    assign unused_bits     = ^{cp0_wreq.sel, regs_reg.cause.ip[7:2], regs_reg.cause.ti};

endmodule

// File: tb/tb_cp0_core_param.sv
// Bench for cp0_core_param: directed scenarios plus random traffic, all
// checked every cycle against a behavioural CP0 model.
module tb_cp0_core_param;
    import cp0_core_param_pkg::*;

    localparam int          N_HW   = 6;
    localparam int          DIV    = 4;
    localparam int          TIP    = 7;
    localparam logic [31:0] PRID   = 32'h0001_8000;
    localparam logic [31:0] CONFIG = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    cp0_rreq_t       rreq;
    cp0_wreq_t       wreq;
    logic [N_HW-1:0] hw;
    exception_sign_t esign;
    exception_data_t edata;
    logic [31:0]     rdata, status, cause, epc;
    logic            ti, pend;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_core_param #(
        .N_HW_INT(N_HW), .COUNT_DIV(DIV), .PRID_VAL(PRID),
        .CONFIG_VAL(CONFIG), .TIMER_IP(TIP)
    ) dut (
        .clk(clk), .rst(rst), .cp0_rreq(rreq), .cp0_rdata(rdata), .cp0_wreq(wreq),
        .hw_int(hw), .exception_sign(esign), .exception_data(edata),
        .cp0_status(status), .cp0_cause(cause), .cp0_epc(epc),
        .timer_interrupt(ti), .int_pending(pend)
    );

    // Behavioural model state
    logic [31:0]     m_count, m_compare, m_epc, m_badv;
    int              m_ticks;
    logic [7:0]      m_im;
    logic            m_exl, m_ie, m_erl, m_bd, m_ti, m_pend;
    logic [4:0]      m_exc;
    logic [1:0]      m_ipsw;
    logic [N_HW-1:0] m_s1, m_s2;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_ip();
        logic [7:0] v;
        v = 8'h00;
        v[1:0] = m_ipsw;
        for (int i = 0; i < N_HW; i++) v[2+i] = m_s2[i];
        if (m_ti) v[TIP] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] m_status();
        return {9'b0, 1'b1, 6'b0, m_im, 5'b0, m_erl, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exc, 2'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epc;
            5'd15: return (s == 3'd0) ? PRID : 32'h0;
            5'd16: return CONFIG;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_ticks = 0;
        m_im = 0; m_exl = 0; m_ie = 0; m_erl = 0; m_bd = 0; m_ti = 0; m_pend = 0;
        m_exc = 0; m_ipsw = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step();
        logic       exl0, erl0, pend1;
        logic [7:0] ip0;
        exl0  = m_exl;
        erl0  = m_erl;
        ip0   = m_ip();
        pend1 = m_ie && !m_exl && !m_erl && ((ip0 & m_im) != 8'h00);
        if (wreq.we && wreq.addr == 5'd11) m_ti = 1'b0;
        else if (m_count == m_compare)     m_ti = 1'b1;
        if (wreq.we && wreq.addr == 5'd11) m_compare = wreq.wdata;
        if (wreq.we && wreq.addr == 5'd9) begin
            m_count = wreq.wdata;
            m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_ticks % DIV == 0) m_count = m_count + 1;
        end
        m_s2 = m_s1;
        m_s1 = hw;
        if (wreq.we && wreq.addr == 5'd12) begin
            m_im  = wreq.wdata[15:8];
            m_exl = wreq.wdata[1];
            m_ie  = wreq.wdata[0];
        end
        if (wreq.we && wreq.addr == 5'd13) m_ipsw = wreq.wdata[9:8];
        if (wreq.we && wreq.addr == 5'd14 && !esign.valid) m_epc = wreq.wdata;
        if (esign.is_eret) begin
            if (erl0) m_erl = 1'b0;
            else      m_exl = 1'b0;
        end
        if (esign.valid) begin
            m_exl = 1'b1;
            m_exc = edata.exccode;
            if (!exl0) begin
                m_bd  = esign.delayslot;
                m_epc = esign.delayslot ? esign.pc - 32'd4 : esign.pc;
            end
            if (edata.exccode == 5'd4 || edata.exccode == 5'd5) m_badv = esign.badvaddr;
        end
        m_pend = pend1;
    endtask

    task automatic compare_all();
        check_value("status", status, m_status());
        check_value("cause", cause, m_cause());
        check_value("epc", epc, m_epc);
        check_value("ti", 32'(ti), 32'(m_ti));
        check_value("pend", 32'(pend), 32'(m_pend));
        check_value("rdata", rdata, m_read(rreq.addr, rreq.sel));
    endtask

    // One clock: inputs set before the call are sampled, one-shot requests then drop.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        @(negedge clk);
        wreq.we       = 1'b0;
        esign.valid   = 1'b0;
        esign.is_eret = 1'b0;
        compare_all();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wreq.we = 1'b1; wreq.addr = a; wreq.sel = 3'd0; wreq.wdata = d;
        cycle();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] raddrs [9];
        logic [4:0] waddrs [6];
        logic [4:0] codes  [6];
        int         n;
        raddrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};
        waddrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        codes  = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd12, 5'd10};
        rreq = '0; wreq = '0; hw = '0; esign = '0; edata = '0;
        model_reset();

        $display("scenario: reset values");
        @(negedge clk);
        cycles(2);
        check_value("rst_status", status, 32'h0040_0000);
        check_value("rst_cause", cause, 32'h0);
        check_value("rst_epc", epc, 32'h0);
        check_value("rst_ti", 32'(ti), 32'h0);
        check_value("rst_pend", 32'(pend), 32'h0);

        $display("scenario: prescaled count after release");
        rreq.addr = 5'd9;
        rst = 1'b1;
        cycles(4);
        check_value("cnt_4", rdata, 32'd1);
        cycles(96);
        check_value("cnt_100", rdata, 32'd25);

        $display("scenario: timer match and compare write");
        mtc0(5'd11, 32'd10);
        check_value("ti_clr", 32'(ti), 32'h0);
        mtc0(5'd9, 32'd0);
        n = 0;
        while (m_count != 32'd10 && n < 200) begin cycle(); n++; end
        check_value("t_reach", rdata, 32'd10);
        cycle();
        check_value("ti_set", 32'(ti), 32'h1);
        mtc0(5'd11, 32'd20);
        check_value("ti_cmpw", 32'(ti), 32'h0);

        $display("scenario: hardware interrupt path");
        mtc0(5'd12, 32'h0000_0401);
        hw = 6'b000001;
        cycle();
        check_value("ip2_1", 32'(cause[10]), 32'h0);
        cycle();
        check_value("ip2_2", 32'(cause[10]), 32'h1);
        cycle();
        check_value("pend_3", 32'(pend), 32'h1);
        hw = '0;
        mtc0(5'd12, 32'h0000_0403);
        cycle();
        check_value("pend_exl", 32'(pend), 32'h0);
        mtc0(5'd12, 32'h0);

        $display("scenario: exceptions, eret, priority");
        rreq.addr = 5'd8;
        esign = '{valid: 1'b1, pc: 32'hBFC0_0100, delayslot: 1'b1, badvaddr: 32'h1, is_eret: 1'b0};
        edata.exccode = CODE_ADEL;
        cycle();
        check_value("exc_epc", epc, 32'hBFC0_00FC);
        check_value("exc_bd", 32'(cause[31]), 32'h1);
        check_value("exc_badv", rdata, 32'h1);
        check_value("exc_exl", 32'(status[1]), 32'h1);
        esign = '{valid: 1'b1, pc: 32'h8000_1000, delayslot: 1'b0, badvaddr: 32'hDEAD, is_eret: 1'b0};
        edata.exccode = CODE_OV;
        cycle();
        check_value("exc2_epc", epc, 32'hBFC0_00FC);
        check_value("exc2_code", 32'(cause[6:2]), 32'd12);
        check_value("exc2_badv", rdata, 32'h1);
        esign.is_eret = 1'b1;
        cycle();
        check_value("eret_exl", 32'(status[1]), 32'h0);
        esign = '{valid: 1'b1, pc: 32'h8000_0200, delayslot: 1'b0, badvaddr: 32'h0, is_eret: 1'b1};
        edata.exccode = CODE_SYS;
        mtc0(5'd14, 32'h1234_5678);
        check_value("prio_exl", 32'(status[1]), 32'h1);
        check_value("prio_epc", epc, 32'h8000_0200);
        esign.is_eret = 1'b1;
        cycle();

        $display("scenario: count wrap and reload mid-prescale");
        rreq.addr = 5'd9;
        mtc0(5'd9, 32'hFFFF_FFFF);
        cycles(DIV);
        check_value("wrap", rdata, 32'h0);
        cycles(2);
        mtc0(5'd9, 32'd5);
        cycles(DIV - 1);
        check_value("load_hold", rdata, 32'd5);
        cycle();
        check_value("load_inc", rdata, 32'd6);

        $display("scenario: fixed read-only registers");
        rreq = '{addr: 5'd15, sel: 3'd0}; #1 check_value("prid", rdata, PRID);
        rreq = '{addr: 5'd15, sel: 3'd1}; #1 check_value("prid_sel1", rdata, 32'h0);
        rreq = '{addr: 5'd16, sel: 3'd0}; #1 check_value("config", rdata, CONFIG);
        rreq = '{addr: 5'd3,  sel: 3'd0}; #1 check_value("unmapped", rdata, 32'h0);

        $display("scenario: asynchronous reset mid-operation");
        mtc0(5'd12, 32'h0000_FF01);
        rreq.addr = 5'd9;
        mtc0(5'd9, 32'h0000_0077);
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        check_value("mid_rst_cnt", rdata, 32'h0);
        check_value("mid_rst_status", status, 32'h0040_0000);
        cycles(2);
        rst = 1'b1;
        cycles(DIV - 1);
        check_value("mid_rel_hold", rdata, 32'h0);
        cycle();
        check_value("mid_rel_inc", rdata, 32'h1);

        $display("scenario: random traffic");
        for (int k = 0; k < 1500; k++) begin
            rreq.addr = raddrs[$urandom_range(0, 8)];
            rreq.sel  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            if ($urandom_range(0, 7) == 0) hw = N_HW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wreq.we    = 1'b1;
                wreq.addr  = waddrs[$urandom_range(0, 5)];
                wreq.sel   = 3'd0;
                wreq.wdata = $urandom;
                if (wreq.addr == 5'd11 && $urandom_range(0, 1) == 1)
                    wreq.wdata = m_count + 32'($urandom_range(0, 3));
                if (wreq.addr == 5'd9 && $urandom_range(0, 3) == 0)
                    wreq.wdata = 32'hFFFF_FFFE;
            end
            if ($urandom_range(0, 15) == 0) begin
                esign.valid     = 1'b1;
                esign.pc        = $urandom & 32'hFFFF_FFFC;
                esign.delayslot = 1'($urandom);
                esign.badvaddr  = $urandom;
                edata.exccode   = codes[$urandom_range(0, 5)];
            end
            esign.is_eret = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
